// File: rtl/mipscpu.sv
// Single-cycle ALU plus a 16-phase step timer that advances the PC once per timer wrap.
// Optional SLT support is enabled by defining MIPSCPU_SLT_EN.
module mipscpu #(
   parameter int WORD_SIZE = 16,
   parameter int OP_SIZE   = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 key_ok,
   input  logic [WORD_SIZE-1:0] data_1,
   input  logic [WORD_SIZE-1:0] data_2,
   input  logic [OP_SIZE-1:0]   sel,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 load_pc,
   input  logic                 offset,
   output logic [3:0]           timer,
   output logic [WORD_SIZE-1:0] alu_out,
   output logic                 alu_zero_flag,
   output logic [WORD_SIZE-1:0] pc_counter
);

   localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(5);
   localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(6);
   localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(7);
   localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(8);
`ifdef MIPSCPU_SLT_EN
   localparam logic [OP_SIZE-1:0] OP_SLT = OP_SIZE'(9);
`endif

   logic [3:0]           timer_q, timer_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic                 tick;

   always_comb begin
      alu_out = '0;
      case (sel)
         OP_AND:  alu_out = data_1 & data_2;
         OP_OR:   alu_out = data_1 | data_2;
         OP_ADD:  alu_out = data_1 + data_2;
         OP_SUB:  alu_out = data_1 - data_2;
`ifdef MIPSCPU_SLT_EN
         OP_SLT:  alu_out = {{(WORD_SIZE-1){1'b0}}, ($signed(data_1) < $signed(data_2))};
`endif
         default: alu_out = '0;
      endcase
   end

   assign alu_zero_flag = (alu_out == '0);

   // A tick is the enabled edge on which the timer wraps 15 -> 0.
   assign tick = key_ok && (timer_q == 4'hF);

   always_comb begin
      timer_d = key_ok ? timer_q + 4'd1 : timer_q;
      pc_d    = pc_q;
      if (tick) begin
         if (load_pc)     pc_d = data_in;
         else if (offset) pc_d = pc_q + WORD_SIZE'(1) + data_in;
         else             pc_d = pc_q + WORD_SIZE'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timer_q <= 4'd0;
         pc_q    <= '0;
      end else begin
         timer_q <= timer_d;
         pc_q    <= pc_d;
      end
   end

   assign timer      = timer_q;
   assign pc_counter = pc_q;

endmodule

// File: tb/tb_mipscpu.sv
// Directed bench for mipscpu: PC/timer stepping via a scoreboard queue, plus ALU vectors.
module tb_mipscpu;
   logic        clk, rstn, key_ok, load_pc, offset;
   logic [15:0] data_1, data_2, data_in;
   logic [3:0]  sel;
   logic [3:0]  timer;
   logic [15:0] alu_out, pc_counter;
   logic        alu_zero_flag;

   int checks = 0;
   int errors = 0;
   int t_m = 0;
   logic [15:0] pc_m = 16'h0;
   logic [15:0] pc_sb[$];
   logic [16:0] alu_sb[$];

   mipscpu #(.WORD_SIZE(16), .OP_SIZE(4)) dut (
      .clk(clk), .rstn(rstn), .key_ok(key_ok), .data_1(data_1), .data_2(data_2),
      .sel(sel), .data_in(data_in), .load_pc(load_pc), .offset(offset),
      .timer(timer), .alu_out(alu_out), .alu_zero_flag(alu_zero_flag),
      .pc_counter(pc_counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (key_ok) t_m = (t_m + 1) % 16;
      end
   endtask

   // Push the expected next PC, run to the tick, and compare.
   task automatic do_tick(input string tag);
      logic [15:0] exp;
      if (load_pc)     exp = data_in;
      else if (offset) exp = pc_m + 16'd1 + data_in;
      else             exp = pc_m + 16'd1;
      pc_sb.push_back(exp);
      edges(15 - t_m);
      chk({tag, "_hold"}, {16'h0, pc_counter}, {16'h0, pc_m});
      chk({tag, "_t15"}, {28'h0, timer}, 32'd15);
      edges(1);
      pc_m = pc_sb.pop_front();
      chk({tag, "_pc"}, {16'h0, pc_counter}, {16'h0, pc_m});
      chk({tag, "_t0"}, {28'h0, timer}, 32'd0);
   endtask

   task automatic alu_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic [15:0] exp);
      logic [16:0] e;
      data_1 = a; data_2 = b; sel = s;
      alu_sb.push_back({(exp == 16'h0), exp});
      #1;
      e = alu_sb.pop_front();
      chk({tag, "_out"}, {16'h0, alu_out}, {16'h0, e[15:0]});
      chk({tag, "_z"}, {31'h0, alu_zero_flag}, {31'h0, e[16]});
   endtask

   localparam logic [15:0] SLT1 =
`ifdef MIPSCPU_SLT_EN
      16'h0001;
`else
      16'h0000;
`endif

   initial begin
      rstn = 1'b0; key_ok = 1'b1; load_pc = 1'b0; offset = 1'b0;
      data_1 = '0; data_2 = '0; data_in = '0; sel = '0;
      #2;
      chk("rst_timer", {28'h0, timer}, 32'd0);
      chk("rst_pc", {16'h0, pc_counter}, 32'd0);
      alu_chk("rst_alu_add", 16'h0004, 16'h0005, 4'b0111, 16'h0009);
      edges(3);
      t_m = 0;
      chk("rst_hold_timer", {28'h0, timer}, 32'd0);
      rstn = 1'b1;

      edges(1);
      chk("cnt1", {28'h0, timer}, 32'd1);
      do_tick("first");

      load_pc = 1'b1; data_in = 16'h0003;
      do_tick("load3");
      do_tick("load3_again");

      load_pc = 1'b0; offset = 1'b1; data_in = 16'h0004;
      do_tick("off4");
      offset = 1'b0;
      do_tick("inc9");

      load_pc = 1'b1; data_in = 16'hFFFF;
      do_tick("loadffff");
      load_pc = 1'b0;
      do_tick("wrap_inc");
      offset = 1'b1; data_in = 16'hFFFE;
      do_tick("off_fffe");
      data_in = 16'h0001;
      do_tick("off_wrap");
      offset = 1'b0;

      edges(3);
      key_ok = 1'b0; load_pc = 1'b1; data_in = 16'h1234;
      edges(20);
      chk("hold_timer", {28'h0, timer}, 32'd3);
      chk("hold_pc", {16'h0, pc_counter}, {16'h0, pc_m});
      key_ok = 1'b1; load_pc = 1'b0;
      edges(4);
      chk("pre_rst_t7", {28'h0, timer}, 32'd7);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_timer", {28'h0, timer}, 32'd0);
      chk("async_rst_pc", {16'h0, pc_counter}, 32'd0);
      #1 rstn = 1'b1;
      t_m = 0; pc_m = 16'h0;
      do_tick("after_rst");

      alu_chk("add", 16'h0004, 16'h0005, 4'b0111, 16'h0009);
      alu_chk("sub", 16'h0004, 16'h0005, 4'b1000, 16'hFFFF);
      alu_chk("and", 16'h0004, 16'h0005, 4'b0101, 16'h0004);
      alu_chk("or",  16'h0004, 16'h0005, 4'b0110, 16'h0005);
      alu_chk("slt", 16'h0004, 16'h0005, 4'b1001, SLT1);
      alu_chk("slt_neg", 16'h8000, 16'h0001, 4'b1001, SLT1);
      alu_chk("slt_ge", 16'h0005, 16'h8000, 4'b1001, 16'h0000);
      alu_chk("sub_zero", 16'h0005, 16'h0005, 4'b1000, 16'h0000);
      alu_chk("add_wrap", 16'hFFFF, 16'h0002, 4'b0111, 16'h0001);
      alu_chk("sel0", 16'h0004, 16'h0005, 4'b0000, 16'h0000);
      alu_chk("sel15", 16'hFFFF, 16'hFFFF, 4'b1111, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mipscpu.md
MIPSCPU -- requirements
Module: mipscpu

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the data, ALU and PC width.
REQ-002 Parameter OP_SIZE, default 4, SHALL set the ALU select width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 Port key_ok, input, 1: step enable, active-high.
REQ-006 Port data_1, input, WORD_SIZE: ALU operand A.
REQ-007 Port data_2, input, WORD_SIZE: ALU operand B.
REQ-008 Port sel, input, OP_SIZE: ALU operation select.
REQ-009 Port data_in, input, WORD_SIZE: PC load value or branch offset.
REQ-010 Port load_pc, input, 1: PC load request.
REQ-011 Port offset, input, 1: PC relative-branch request.
REQ-012 Port timer, output, 4: step-phase counter.
REQ-013 Port alu_out, output, WORD_SIZE: ALU result.
REQ-014 Port alu_zero_flag, output, 1: high when alu_out is zero.
REQ-015 Port pc_counter, output, WORD_SIZE: program counter.

Function
REQ-016 The ALU SHALL be purely combinational with zero latency from data_1, data_2 and sel to alu_out.
REQ-017 ALU operations SHALL be: sel=4'b0101 gives A AND B; 4'b0110 gives A OR B; 4'b0111 gives A+B modulo 2^WORD_SIZE with carry discarded; 4'b1000 gives A-B modulo 2^WORD_SIZE (two's complement wrap).
REQ-018 sel=4'b1001 (SLT) SHALL give 1 when A<B as signed two's complement values, else 0, zero-extended to WORD_SIZE.
REQ-019 Any other sel value SHALL give alu_out=0.
REQ-020 alu_zero_flag SHALL equal (alu_out==0) combinationally.
REQ-021 timer SHALL increment by 1 on each clk edge while key_ok=1, wrap from 15 to 0, and hold while key_ok=0.
REQ-022 A step tick SHALL occur on a clk edge where key_ok=1 and timer==15.
REQ-023 On a tick, pc_counter SHALL update with priority load_pc, then offset, then default: load_pc=1 gives data_in; else offset=1 gives pc+1+data_in; else pc+1.
REQ-024 All PC arithmetic SHALL wrap modulo 2^WORD_SIZE.
REQ-025 pc_counter SHALL hold between ticks; load_pc and offset SHALL be ignored off-tick.

Reset
REQ-026 rstn=0 SHALL immediately, without waiting for clk, force timer=0 and pc_counter=0.
REQ-027 While rstn=0, alu_out and alu_zero_flag SHALL still follow their combinational inputs.
REQ-028 Reset asserted mid-step SHALL abandon the pending tick; after release, counting SHALL restart from timer=0, so the first tick falls on the 16th enabled edge.

Configuration
REQ-029 With macro MIPSCPU_SLT_EN defined, SLT SHALL behave per REQ-018.
REQ-030 With MIPSCPU_SLT_EN undefined, sel=4'b1001 SHALL be treated as an unsupported code, giving alu_out=0 and alu_zero_flag=1.

Verification
REQ-031 rstn=0 then released with key_ok=1 -> timer=0 and pc_counter=0000 during reset; timer counts 0..15 and wraps after release.
REQ-032 load_pc=1, data_in=0003 -> pc_counter=0003 after the next tick, and stays 0003 on later ticks while load_pc remains 1.
REQ-033 load_pc=0, offset=1, data_in=0004, pc=0003 -> pc_counter=0008 after the next tick; offset=0 -> 0009 after the following tick.
REQ-034 A=0004, B=0005, stepping sel -> ADD gives 0009, SUB gives FFFF, AND gives 0004, OR gives 0005, SLT gives 0001 (macro defined); alu_zero_flag=0 for all five.
REQ-035 A=8000, B=0001, SLT -> 0001; A=B=0005, SUB -> 0000 with alu_zero_flag=1; sel=0000 -> 0000 with alu_zero_flag=1.
REQ-036 key_ok=0 held for 20 cycles -> timer and pc_counter unchanged; rstn pulsed low between clk edges at timer=7 -> timer=0 immediately.
